// File: rtl/ctl_seq_if.sv
// Instruction-memory fetch bus between the sequencer (master) and the 4-bit program memory (slave).
interface ctl_seq_if #(
  parameter int PC_LEN   = 6,
  parameter int DATA_LEN = 4
);
  logic                IMEM_REQ;
  logic [PC_LEN:0]     IMEM_ADDR;
  logic                IMEM_ACK;
  logic [DATA_LEN-1:0] IMEM_RDATA;

  modport master (output IMEM_REQ, IMEM_ADDR, input IMEM_ACK, IMEM_RDATA);
  modport slave  (input IMEM_REQ, IMEM_ADDR, output IMEM_ACK, IMEM_RDATA);
endinterface

// File: rtl/ctl_seq.sv
// Multi-cycle sequencer for the 4-bit accumulator datapath: two-nibble fetch, one-cycle EX decode.
// Optional single-step mode (STEP input, HOLD state) is built when CTL_STEP_EN is defined.
module ctl_seq #(
  parameter int PC_LEN     = 6,
  parameter int ALU_OP_LEN = 2,
  parameter int DATA_LEN   = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
`ifdef CTL_STEP_EN
  input  logic                  STEP,
`endif
  input  logic [PC_LEN-1:0]     PC,
  ctl_seq_if.master             imem,
  output logic                  PC_EN,
  output logic                  A_EN,
  output logic [ALU_OP_LEN-1:0] ALU_OP,
  output logic [DATA_LEN-1:0]   INSTR_IMM,
  output logic                  IMM_SEL,
  output logic [PC_LEN-1:0]     BR_TARGET,
  output logic                  IS_BR,
  output logic                  IS_LD,
  output logic                  IS_ST,
  output logic [2:0]            REG_ID
);

  typedef enum logic [1:0] {
    F_HI = 2'd0,
    F_LO = 2'd1,
    EX   = 2'd2,
    HOLD = 2'd3
  } state_t;

`ifdef CTL_STEP_EN
  localparam state_t RST_STATE = HOLD;
`else
  localparam state_t RST_STATE = F_HI;
`endif

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] nib;
  logic [3:0] opc;
  logic [3:0] lo;
  logic [5:0] br_tgt6;

  assign nib     = 4'(imem.IMEM_RDATA);
  assign opc     = ir_q[7:4];
  assign lo      = ir_q[3:0];
  assign br_tgt6 = {opc[1:0], lo};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= RST_STATE;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      F_HI: begin
        if (imem.IMEM_ACK) begin
          ir_d[7:4] = nib;
          state_d   = F_LO;
        end
      end
      F_LO: begin
        if (imem.IMEM_ACK) begin
          ir_d[3:0] = nib;
          state_d   = EX;
        end
      end
      EX: begin
`ifdef CTL_STEP_EN
        state_d = HOLD;
`else
        state_d = F_HI;
`endif
      end
      HOLD: begin
`ifdef CTL_STEP_EN
        if (STEP) state_d = F_HI;
`else
        state_d = F_HI;
`endif
      end
      default: state_d = RST_STATE;
    endcase
  end

  // REQ is gated by RSTN so it drops the moment reset asserts, not at the next edge.
  assign imem.IMEM_REQ  = RSTN & ((state_q == F_HI) | (state_q == F_LO));
  assign imem.IMEM_ADDR = {PC, (state_q == F_LO)};

  always_comb begin
    PC_EN     = 1'b0;
    A_EN      = 1'b0;
    ALU_OP    = '0;
    INSTR_IMM = '0;
    IMM_SEL   = 1'b0;
    BR_TARGET = '0;
    IS_BR     = 1'b0;
    IS_LD     = 1'b0;
    IS_ST     = 1'b0;
    REG_ID    = '0;
    if (state_q == EX) begin
      PC_EN     = 1'b1;
      ALU_OP    = ALU_OP_LEN'(opc[1:0]);
      INSTR_IMM = DATA_LEN'(lo);
      case (opc[3:2])
        2'b00: REG_ID = lo[2:0];
        2'b01: IMM_SEL = 1'b1;
        2'b10: begin
          IS_LD  = ~opc[0];
          IS_ST  = opc[0];
          REG_ID = lo[2:0];
        end
        default: begin
          IS_BR     = 1'b1;
          BR_TARGET = PC_LEN'(br_tgt6);
        end
      endcase
      A_EN = ~IS_BR & ~IS_ST;
    end
  end

endmodule

// File: tb/tb_ctl_seq.sv
// Scoreboard bench for ctl_seq: program memory model, PC model, per-scenario test tasks.
module tb_ctl_seq;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [5:0]  PC;
  logic        PC_EN, A_EN, IMM_SEL, IS_BR, IS_LD, IS_ST;
  logic [1:0]  ALU_OP;
  logic [3:0]  INSTR_IMM;
  logic [5:0]  BR_TARGET;
  logic [2:0]  REG_ID;
`ifdef CTL_STEP_EN
  logic        STEP = 1'b0;
`endif

  ctl_seq_if #(.PC_LEN(6), .DATA_LEN(4)) imem ();

  ctl_seq #(.PC_LEN(6), .ALU_OP_LEN(2), .DATA_LEN(4)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
`ifdef CTL_STEP_EN
    .STEP      (STEP),
`endif
    .PC        (PC),
    .imem      (imem),
    .PC_EN     (PC_EN),
    .A_EN      (A_EN),
    .ALU_OP    (ALU_OP),
    .INSTR_IMM (INSTR_IMM),
    .IMM_SEL   (IMM_SEL),
    .BR_TARGET (BR_TARGET),
    .IS_BR     (IS_BR),
    .IS_LD     (IS_LD),
    .IS_ST     (IS_ST),
    .REG_ID    (REG_ID)
  );

  always #5 CLK = ~CLK;

  logic [3:0]  mem [0:127];
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt;
  logic [5:0]  pc_init = 6'd0;
  logic [20:0] sb_q [$];
  int          checks = 0;
  int          failures = 0;

  // Memory answers after ack_delay wait cycles; force_ack holds ACK high regardless of REQ.
  assign imem.IMEM_ACK   = force_ack | (imem.IMEM_REQ && (wait_cnt >= ack_delay));
  assign imem.IMEM_RDATA = mem[imem.IMEM_ADDR];

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) wait_cnt <= 0;
    else if (!imem.IMEM_REQ || imem.IMEM_ACK) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) PC <= pc_init;
    else if (PC_EN) PC <= IS_BR ? BR_TARGET : PC + 6'd1;
  end

  function automatic logic [20:0] exp_ctl(input logic [7:0] b);
    logic [3:0] opc, lo;
    logic       br, ld, st, isel;
    logic [2:0] rid;
    logic [5:0] tgt;
    opc = b[7:4]; lo = b[3:0];
    br = 1'b0; ld = 1'b0; st = 1'b0; isel = 1'b0; rid = 3'd0; tgt = 6'd0;
    case (opc[3:2])
      2'b00: rid = lo[2:0];
      2'b01: isel = 1'b1;
      2'b10: begin ld = ~opc[0]; st = opc[0]; rid = lo[2:0]; end
      default: begin br = 1'b1; tgt = {opc[1:0], lo}; end
    endcase
    return {1'b1, ~(br | st), opc[1:0], lo, isel, tgt, br, ld, st, rid};
  endfunction

  function automatic logic [20:0] act_ctl();
    return {PC_EN, A_EN, ALU_OP, INSTR_IMM, IMM_SEL, BR_TARGET, IS_BR, IS_LD, IS_ST, REG_ID};
  endfunction

  task automatic load_instr(input logic [5:0] a, input logic [7:0] b);
    mem[{a, 1'b0}] = b[7:4];
    mem[{a, 1'b1}] = b[3:0];
    sb_q.push_back(exp_ctl(b));
  endtask

  // Release just after a rising edge, so the next falling edge samples cycle 1.
  task automatic do_reset(input logic [5:0] p);
    RSTN    = 1'b0;
    pc_init = p;
    sb_q.delete();
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] a;
    force_ack = 1'b1;
    RSTN = 1'b0;
    pc_init = 6'h0A;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    a = act_ctl();
    checks++;
    if (imem.IMEM_REQ !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem.IMEM_REQ); end
    checks++;
    if (imem.IMEM_ADDR !== {6'h0A, 1'b0}) begin failures++; $display("FAIL rst_addr got=%h want=%h", imem.IMEM_ADDR, {6'h0A, 1'b0}); end
    checks++;
    if (a !== 21'd0) begin failures++; $display("FAIL rst_ctl got=%h want=0", a); end
    force_ack = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [20:0] e, a;
    ack_delay = 0;
    do_reset(6'd0);
    load_instr(6'd0, 8'h53);
    load_instr(6'd1, 8'h82);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checks++;
      if (imem.IMEM_REQ !== (c % 3 != 0)) begin failures++; $display("FAIL zw_req c=%0d got=%b want=%b", c, imem.IMEM_REQ, (c % 3 != 0)); end
      checks++;
      if (PC_EN !== (c % 3 == 0)) begin failures++; $display("FAIL zw_pc_en c=%0d got=%b want=%b", c, PC_EN, (c % 3 == 0)); end
      if (c == 3) begin
        checks++;
        if ({IMM_SEL, ALU_OP, INSTR_IMM, A_EN, PC_EN} !== {1'b1, 2'd1, 4'd3, 1'b1, 1'b1}) begin
          failures++; $display("FAIL zw_ex1 got=%b want=%b", {IMM_SEL, ALU_OP, INSTR_IMM, A_EN, PC_EN}, {1'b1, 2'd1, 4'd3, 1'b1, 1'b1});
        end
      end
      if (c == 6) begin
        checks++;
        if ({IS_LD, REG_ID} !== {1'b1, 3'd2}) begin failures++; $display("FAIL zw_ex2 got=%b want=%b", {IS_LD, REG_ID}, {1'b1, 3'd2}); end
      end
      if (PC_EN === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL zw_sb unexpected EX got=%h want=none", act_ctl()); end
        else begin
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL zw_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL zw_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_wait_states();
    logic [20:0] e, a;
    ack_delay = 2;
    do_reset(6'd0);
    load_instr(6'd0, 8'h2B);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      checks++;
      if (imem.IMEM_REQ !== (c < 7)) begin failures++; $display("FAIL ws_req c=%0d got=%b want=%b", c, imem.IMEM_REQ, (c < 7)); end
      if (c < 7) begin
        checks++;
        if (imem.IMEM_ADDR !== {6'd0, (c > 3)}) begin failures++; $display("FAIL ws_addr c=%0d got=%h want=%h", c, imem.IMEM_ADDR, {6'd0, (c > 3)}); end
      end
      checks++;
      if (PC_EN !== (c == 7)) begin failures++; $display("FAIL ws_ex_time c=%0d got=%b want=%b", c, PC_EN, (c == 7)); end
      if (PC_EN === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL ws_sb unexpected EX got=%h want=none", act_ctl()); end
        else begin
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL ws_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL ws_left got=%0d want=0", sb_q.size()); end
    ack_delay = 0;
  endtask

  task automatic test_store();
    logic [20:0] e, a;
    int st_cycles = 0;
    do_reset(6'd0);
    load_instr(6'd0, 8'h90);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (IS_ST === 1'b1) begin
        st_cycles++;
        checks++;
        if (A_EN !== 1'b0) begin failures++; $display("FAIL st_a_en got=%b want=0", A_EN); end
      end
      if (PC_EN === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL st_sb unexpected EX got=%h want=none", act_ctl()); end
        else begin
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL st_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (st_cycles != 1) begin failures++; $display("FAIL st_cycles got=%0d want=1", st_cycles); end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL st_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_branch();
    logic [20:0] e, a;
    int br_cycles = 0;
    do_reset(6'd0);
    load_instr(6'd0, 8'hE5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (IS_BR === 1'b1) begin
        br_cycles++;
        checks++;
        if ({BR_TARGET, A_EN, PC_EN} !== {6'h25, 1'b0, 1'b1}) begin
          failures++; $display("FAIL br_ctl got=%h/%b/%b want=25/0/1", BR_TARGET, A_EN, PC_EN);
        end
      end
      if (PC_EN === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL br_sb unexpected EX got=%h want=none", act_ctl()); end
        else begin
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL br_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (br_cycles != 1) begin failures++; $display("FAIL br_cycles got=%0d want=1", br_cycles); end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL br_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [20:0] e, a;
    int ex_cnt = 0;
    force_ack = 1'b1;
    do_reset(6'd3);
    load_instr(6'd3, 8'h53);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({imem.IMEM_REQ, imem.IMEM_ADDR} !== {1'b1, 6'd3, 1'b1}) begin
      failures++; $display("FAIL rm_in_flo got=%b/%h want=1/%h", imem.IMEM_REQ, imem.IMEM_ADDR, {6'd3, 1'b1});
    end
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if (imem.IMEM_REQ !== 1'b0) begin failures++; $display("FAIL rm_req_drop got=%b want=0", imem.IMEM_REQ); end
    checks++;
    if (act_ctl() !== 21'd0) begin failures++; $display("FAIL rm_ctl_drop got=%h want=0", act_ctl()); end
    @(posedge CLK);
    #1 RSTN = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      if (c < 3) begin
        checks++;
        if ({imem.IMEM_REQ, imem.IMEM_ADDR} !== {1'b1, 6'd3, (c == 2)}) begin
          failures++; $display("FAIL rm_refetch c=%0d got=%b/%h want=1/%h", c, imem.IMEM_REQ, imem.IMEM_ADDR, {6'd3, (c == 2)});
        end
      end
      if (PC_EN === 1'b1) begin
        ex_cnt++;
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL rm_sb unexpected EX got=%h want=none", act_ctl()); end
        else begin
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL rm_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (ex_cnt != 1) begin failures++; $display("FAIL rm_ex_count got=%0d want=1", ex_cnt); end
    force_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [20:0] e, a;
    logic [7:0]  b;
    int          budget = 80;
    ack_delay = 1;
    do_reset(6'd0);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (b[7:6] == 2'b11) b[7:6] = 2'b00;
      load_instr(6'(i), b);
    end
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (PC_EN === 1'b1) begin
        checks++;
        e = sb_q.pop_front(); a = act_ctl();
        if (a !== e) begin failures++; $display("FAIL b2b_sb got=%h want=%h", a, e); end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_timeout left got=%0d want=0", sb_q.size()); end
    ack_delay = 0;
  endtask

`ifdef CTL_STEP_EN
  task automatic test_step();
    logic [20:0] e, a;
    int ex_cnt = 0;
    STEP = 1'b0;
    do_reset(6'd0);
    load_instr(6'd0, 8'h53);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      checks++;
      if ({imem.IMEM_REQ, PC_EN} !== 2'b00) begin failures++; $display("FAIL step_idle c=%0d got=%b want=00", c, {imem.IMEM_REQ, PC_EN}); end
    end
    STEP = 1'b1;
    @(posedge CLK);
    #1 STEP = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checks++;
      if (imem.IMEM_REQ !== (c < 3)) begin failures++; $display("FAIL step_req c=%0d got=%b want=%b", c, imem.IMEM_REQ, (c < 3)); end
      checks++;
      if (PC_EN !== (c == 3)) begin failures++; $display("FAIL step_ex c=%0d got=%b want=%b", c, PC_EN, (c == 3)); end
      if (PC_EN === 1'b1) begin
        ex_cnt++;
        if (sb_q.size() != 0) begin
          checks++;
          e = sb_q.pop_front(); a = act_ctl();
          if (a !== e) begin failures++; $display("FAIL step_sb got=%h want=%h", a, e); end
        end
      end
    end
    checks++;
    if (ex_cnt != 1) begin failures++; $display("FAIL step_ex_count got=%0d want=1", ex_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 4'h0;
    test_reset();
`ifdef CTL_STEP_EN
    test_step();
`else
    test_zero_wait();
    test_wait_states();
    test_store();
    test_branch();
    test_reset_mid_fetch();
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
